// File: rtl/mmio_bridge_pkg.sv
// rtl/mmio_bridge_pkg.sv - shared constants and read-select encoding for mmio_bridge
package mmio_bridge_pkg;

  localparam logic [1:0]  IO_PAGE   = 2'b11;
  localparam logic [17:0] ADDR_UART = 18'h30000;
  localparam logic [17:0] ADDR_CLK  = 18'h30004;

  // SEL_NONE covers unmapped I/O reads, which return 0x00.
  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_RX,
    SEL_CNT0,
    SEL_CNT1,
    SEL_CNT2,
    SEL_CNT3,
    SEL_NONE
  } rd_sel_t;

endpackage

// File: rtl/mmio_tx_fifo.sv
// rtl/mmio_tx_fifo.sv - synchronous byte FIFO feeding the UART transmitter
//   clk, rst       : clock, synchronous active-high reset
//   push/push_data : enqueue request; dropped when full
//   pop            : dequeue request; ignored when empty
//   data, valid    : head byte, non-empty flag
//   count          : current occupancy
//   almost_full    : registered, set when next occupancy >= DEPTH-MARGIN
module mmio_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] count_next;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign data    = mem[rd_ptr];
  assign valid   = (count != '0);

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  // Storage is never reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      almost_full <= (count_next >= CW'(DEPTH - MARGIN));
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - CPU byte-bus decoder for RAM, UART FIFO, cycle counter and stop flag
//   Optional RX read path enabled by defining MMIO_RX_EN.
//   clk_in, rst_in            : clock, synchronous active-high reset
//   rdy_in                    : CPU ready, qualifies bus accesses
//   mem_a/mem_dout/mem_wr     : CPU request; mem_din returns read data one cycle later
//   io_buffer_full            : TX FIFO near-full
//   ram_a/ram_dout/ram_we     : RAM port; ram_din has 1-cycle latency
//   tx_data/tx_valid/tx_ready : UART TX stream
//   rx_data/rx_valid/rx_pop   : UART RX byte and consume pulse
//   prog_done                 : sticky stop flag set by a write to 0x30004
module mmio_bridge #(
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2,
  parameter int RAM_AW      = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [31:0]       mem_a,
  input  logic [7:0]        mem_dout,
  input  logic              mem_wr,
  output logic [7:0]        mem_din,
  output logic              io_buffer_full,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_we,
  input  logic [7:0]        ram_din,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  output logic              prog_done
);

  import mmio_bridge_pkg::*;

  logic [17:0] addr;
  logic        io;
  logic        rd_req;
  logic        wr_req;
  logic        wr_uart;
  logic        wr_clk;
  rd_sel_t     sel;
  rd_sel_t     sel_next;
  logic        rd_valid;
  logic [7:0]  hold;
  logic [7:0]  live;
  logic [31:0] cnt;
  logic [31:0] snap;
  logic [$clog2(TX_DEPTH):0] tx_count_unused;

  assign addr   = mem_a[17:0];
  assign io     = (addr[17:16] == IO_PAGE);
  assign rd_req = rdy_in && !mem_wr && !rst_in;
  assign wr_req = rdy_in && mem_wr && !rst_in;

  assign ram_a    = rst_in ? '0 : mem_a[RAM_AW-1:0];
  assign ram_dout = rst_in ? '0 : mem_dout;
  assign ram_we   = wr_req && !io;

  // A zero byte to the UART address is a no-op; the stop write forces a 0x00 through.
  assign wr_uart = wr_req && (addr == ADDR_UART) && (mem_dout != 8'h00);
  assign wr_clk  = wr_req && (addr == ADDR_CLK);

  always_comb begin
    sel_next = SEL_RAM;
    if (io) begin
      sel_next = SEL_NONE;
      if (addr == ADDR_UART) begin
        sel_next = SEL_RX;
      end else if ((addr[17:3] == ADDR_CLK[17:3]) && addr[2]) begin
        case (addr[1:0])
          2'd0:    sel_next = SEL_CNT0;
          2'd1:    sel_next = SEL_CNT1;
          2'd2:    sel_next = SEL_CNT2;
          default: sel_next = SEL_CNT3;
        endcase
      end
    end
  end

`ifdef MMIO_RX_EN
  logic       rx_take;
  logic [7:0] rx_byte;
  logic       unused_bits;

  assign rx_take     = rd_req && (addr == ADDR_UART) && rx_valid;
  assign rx_pop      = rx_take;
  assign unused_bits = &{1'b0, mem_a[31:18]};

  // The RX byte is captured with the request because rx_pop consumes it this cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_byte <= 8'h00;
    end else if (rd_req) begin
      rx_byte <= rx_take ? rx_data : 8'h00;
    end
  end
`else
  logic unused_bits;

  assign rx_pop      = 1'b0;
  assign unused_bits = &{1'b0, mem_a[31:18], rx_data, rx_valid};
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt       <= 32'd0;
      snap      <= 32'd0;
      sel       <= SEL_RAM;
      rd_valid  <= 1'b0;
      hold      <= 8'h00;
      prog_done <= 1'b0;
    end else begin
      cnt      <= cnt + 32'd1;
      hold     <= mem_din;
      rd_valid <= rd_req;
      if (rd_req) begin
        sel <= sel_next;
        // Reading byte 0 freezes the whole word so bytes 1-3 match it.
        if (sel_next == SEL_CNT0) snap <= cnt;
      end
      if (wr_clk) prog_done <= 1'b1;
    end
  end

  always_comb begin
    live = 8'h00;
    case (sel)
      SEL_RAM:  live = ram_din;
`ifdef MMIO_RX_EN
      SEL_RX:   live = rx_byte;
`endif
      SEL_CNT0: live = snap[7:0];
      SEL_CNT1: live = snap[15:8];
      SEL_CNT2: live = snap[23:16];
      SEL_CNT3: live = snap[31:24];
      default:  live = 8'h00;
    endcase
  end

  // Outside the cycle after a read, the last returned byte is held.
  assign mem_din = rd_valid ? live : hold;

  mmio_tx_fifo #(
    .DEPTH  (TX_DEPTH),
    .MARGIN (FULL_MARGIN)
  ) u_tx_fifo (
    .clk         (clk_in),
    .rst         (rst_in),
    .push        (wr_uart || wr_clk),
    .push_data   (wr_clk ? 8'h00 : mem_dout),
    .pop         (tx_valid && tx_ready),
    .data        (tx_data),
    .valid       (tx_valid),
    .count       (tx_count_unused),
    .almost_full (io_buffer_full)
  );

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - self-checking bench for mmio_bridge with randomized stimulus
module tb_mmio_bridge;

  localparam int TX_DEPTH    = 16;
  localparam int FULL_MARGIN = 2;
  localparam int RAM_AW      = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [RAM_AW-1:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        prog_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram_mem [0:(1<<RAM_AW)-1];
  logic [7:0] ref_ram [int];
  logic [7:0] got_q [$];

  always #5 clk = ~clk;

  mmio_bridge #(
    .TX_DEPTH(TX_DEPTH), .FULL_MARGIN(FULL_MARGIN), .RAM_AW(RAM_AW)
  ) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_we(ram_we), .ram_din(ram_din),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop), .prog_done(prog_done)
  );

  initial begin
    for (int i = 0; i < (1 << RAM_AW); i++) ram_mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_a] <= ram_dout;
    ram_din <= ram_mem[ram_a];
  end

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b0; mem_wr = 1'b0; mem_a = 32'h0; mem_dout = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    rdy = 1'b1; mem_wr = 1'b1; mem_a = a; mem_dout = d;
    step();
    idle();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [7:0] d);
    rdy = 1'b1; mem_wr = 1'b0; mem_a = a;
    step();
    d = mem_din;
    idle();
  endtask

  function automatic logic [7:0] ref_rd(input int a);
    return ref_ram.exists(a) ? ref_ram[a] : 8'h00;
  endfunction

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; mem_wr = 1'b1; mem_a = 32'h1234; mem_dout = 8'h55;
    rx_valid = 1'b1; rx_data = 8'h33; tx_ready = 1'b0;
    step(); step();
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    total++; if (ram_a !== '0) begin bad++; $display("FAIL reset_ram_a got=%h exp=0", ram_a); end
    total++; if (ram_dout !== 8'h00) begin bad++; $display("FAIL reset_ram_dout got=%h exp=00", ram_dout); end
    total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL reset_mem_din got=%h exp=00", mem_din); end
    total++; if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", io_buffer_full); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    total++; if (rx_pop !== 1'b0) begin bad++; $display("FAIL reset_rx_pop got=%b exp=0", rx_pop); end
    total++; if (prog_done !== 1'b0) begin bad++; $display("FAIL reset_prog_done got=%b exp=0", prog_done); end
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle();
    step();
  endtask

  task automatic test_ram();
    int addrs [$];
    logic [7:0] d;
    logic [7:0] r;
    int a;
    for (int i = 0; i < 8; i++) begin
      a = (i == 0) ? 32'h100 : int'($urandom_range(0, 32'h1FFFF));
      d = (i == 0) ? 8'h41 : 8'($urandom);
      rdy = 1'b1; mem_wr = 1'b1; mem_dout = d;
      mem_a = {14'($urandom), 1'b0, 17'(a)};
      #1;
      total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL ram_we got=%b exp=1", ram_we); end
      total++; if (ram_a !== 17'(a)) begin bad++; $display("FAIL ram_a got=%h exp=%h", ram_a, 17'(a)); end
      total++; if (ram_dout !== d) begin bad++; $display("FAIL ram_dout got=%h exp=%h", ram_dout, d); end
      step();
      idle();
      ref_ram[a] = d;
      addrs.push_back(a);
    end
    foreach (addrs[i]) begin
      bus_read(32'(addrs[i]), r);
      total++;
      if (r !== ref_rd(addrs[i])) begin
        bad++; $display("FAIL ram_read a=%h got=%h exp=%h", addrs[i], r, ref_rd(addrs[i]));
      end
    end
  endtask

  task automatic test_tx_filter();
    logic [7:0] exp_q [$];
    logic [7:0] d;
    got_q.delete();
    tx_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 0) d = 8'h48;
      else if (i == 1) d = 8'h00;
      else if (i == 2) d = 8'h49;
      else d = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      bus_write(32'h30000, d);
      if (d != 8'h00) exp_q.push_back(d);
    end
    for (int i = 0; i < 40 && got_q.size() < exp_q.size(); i++) step();
    step(); step();
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL tx_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL tx_byte idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_full();
    logic [7:0] exp_q [$];
    logic [7:0] d;
    int cnt_m = 0;
    got_q.delete();
    tx_ready = 1'b0;
    for (int k = 0; k < 14; k++) begin
      d = 8'($urandom_range(1, 255));
      bus_write(32'h30000, d);
      exp_q.push_back(d); cnt_m++;
      total++;
      if (io_buffer_full !== (cnt_m >= TX_DEPTH - FULL_MARGIN)) begin
        bad++; $display("FAIL full_fill n=%0d got=%b exp=%b", cnt_m, io_buffer_full, cnt_m >= TX_DEPTH - FULL_MARGIN);
      end
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0; cnt_m--;
    total++;
    if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL full_after_pop got=%b exp=0", io_buffer_full); end
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom_range(1, 255));
      bus_write(32'h30000, d);
      if (cnt_m < TX_DEPTH) begin exp_q.push_back(d); cnt_m++; end
      total++;
      if (io_buffer_full !== (cnt_m >= TX_DEPTH - FULL_MARGIN)) begin
        bad++; $display("FAIL full_refill n=%0d got=%b", cnt_m, io_buffer_full);
      end
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && got_q.size() < exp_q.size(); i++) step();
    step(); step();
    tx_ready = 1'b0;
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL full_drain_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL full_drain_byte idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    total++;
    if (io_buffer_full !== 1'b0 || tx_valid !== 1'b0) begin
      bad++; $display("FAIL full_empty_end full=%b valid=%b exp=0/0", io_buffer_full, tx_valid);
    end
  endtask

  task automatic test_counter();
    logic [7:0] b [4];
    int n;
    for (int t = 0; t < 2; t++) begin
      n = (t == 0) ? 1000 : int'($urandom_range(256, 3000));
      do_reset();
      repeat (n) step();
      rdy = 1'b1; mem_wr = 1'b0;
      for (int k = 0; k < 4; k++) begin
        mem_a = 32'h30004 + 32'(k);
        step();
        b[k] = mem_din;
      end
      idle();
      for (int k = 0; k < 4; k++) begin
        total++;
        if (b[k] !== 8'((n >> (8 * k)) & 255)) begin
          bad++; $display("FAIL counter_byte%0d n=%0d got=%h exp=%h", k, n, b[k], 8'((n >> (8 * k)) & 255));
        end
      end
    end
  endtask

  task automatic test_prog_done();
    do_reset();
    got_q.delete();
    tx_ready = 1'b1;
    total++; if (prog_done !== 1'b0) begin bad++; $display("FAIL prog_done_init got=%b exp=0", prog_done); end
    bus_write(32'h30004, 8'($urandom));
    total++; if (prog_done !== 1'b1) begin bad++; $display("FAIL prog_done_set got=%b exp=1", prog_done); end
    repeat (5) step();
    total++; if (prog_done !== 1'b1) begin bad++; $display("FAIL prog_done_sticky got=%b exp=1", prog_done); end
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h00) begin
      bad++; $display("FAIL prog_done_tx0 n=%0d first=%h exp n=1 byte=00", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(32'h30000, 8'($urandom_range(1, 255)));
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL prog_fifo_loaded got=%b exp=1", tx_valid); end
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (prog_done !== 1'b0) begin bad++; $display("FAIL prog_done_reset got=%b exp=0", prog_done); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL fifo_reset got=%b exp=0", tx_valid); end
    step();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL fifo_reset_hold got=%b exp=0", tx_valid); end
  endtask

  task automatic test_rx();
    logic [7:0] d;
    logic       exp_pop;
    logic [7:0] exp_din;
    for (int t = 0; t < 4; t++) begin
      d = 8'($urandom_range(1, 255));
      rx_valid = (t % 2 == 0);
      rx_data  = d;
`ifdef MMIO_RX_EN
      exp_pop = rx_valid;
      exp_din = rx_valid ? d : 8'h00;
`else
      exp_pop = 1'b0;
      exp_din = 8'h00;
`endif
      rdy = 1'b1; mem_wr = 1'b0; mem_a = 32'h30000;
      #1;
      total++; if (rx_pop !== exp_pop) begin bad++; $display("FAIL rx_pop t=%0d got=%b exp=%b", t, rx_pop, exp_pop); end
      step();
      idle();
      rx_valid = 1'b0;
      total++; if (mem_din !== exp_din) begin bad++; $display("FAIL rx_data t=%0d got=%h exp=%h", t, mem_din, exp_din); end
      total++; if (rx_pop !== 1'b0) begin bad++; $display("FAIL rx_pop_pulse t=%0d got=%b exp=0", t, rx_pop); end
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] r;
    int a;
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_write(32'h200, 8'($urandom_range(1, 255)));
      ref_ram[32'h200] = ram_mem[32'h200];
      bus_read(32'h200, r);
      a = 32'h30008 + int'($urandom_range(0, 32'hFFF0));
      bus_read(32'(a), r);
      total++; if (r !== 8'h00) begin bad++; $display("FAIL unmapped_read a=%h got=%h exp=00", a, r); end
      rdy = 1'b1; mem_wr = 1'b1; mem_a = 32'(a); mem_dout = 8'($urandom_range(1, 255));
      #1;
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL io_ram_we a=%h got=%b exp=0", a, ram_we); end
      step();
      idle();
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL io_write_push a=%h got=%b exp=0", a, tx_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_din = 8'h00;
    logic       checkable = 1'b0;
    logic [7:0] d;
    int a;
    int op;
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 2));
      a  = ($urandom_range(0, 7) == 0) ? 32'h1FFFF : 32'h10 + int'($urandom_range(0, 7));
      if (op == 0) begin
        d = 8'($urandom);
        rdy = 1'b1; mem_wr = 1'b1; mem_a = 32'(a); mem_dout = d;
        ref_ram[a] = d;
        checkable = 1'b0;
      end else if (op == 1) begin
        rdy = 1'b1; mem_wr = 1'b0; mem_a = 32'(a);
        exp_din = ref_rd(a);
        checkable = 1'b1;
      end else begin
        rdy = 1'b0; mem_wr = $urandom_range(0, 1) == 1; mem_a = 32'(a);
      end
      step();
      if (checkable) begin
        total++;
        if (mem_din !== exp_din) begin
          bad++; $display("FAIL b2b i=%0d op=%0d got=%h exp=%h", i, op, mem_din, exp_din);
        end
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle();
    test_reset();
    test_ram();
    test_tx_filter();
    test_full();
    test_counter();
    test_prog_done();
    test_rx();
    test_unmapped();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
